// File: rtl/pkt_cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_cache_pkg : header format, type codes and FSM state encodings     |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
package pkt_cache_pkg;

  localparam logic [31:0] HDR_MASK = 32'hFF00_00FF;

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_1    = 3'd1;
  localparam logic [2:0] TYPE_2    = 3'd2;
  localparam logic [2:0] TYPE_3    = 3'd3;
  localparam logic [2:0] TYPE_4    = 3'd4;
  localparam logic [2:0] TYPE_5    = 3'd5;

  typedef enum logic [1:0] {
    W_HDR  = 2'd0,
    W_PAY  = 2'd1,
    W_DROP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RUN  = 2'd1,
    R_LAST = 2'd2
  } rd_state_t;

  // TYPE_NONE marks a word that is not a usable header.
  function automatic logic [2:0] hdr_type(input logic [31:0] w);
    logic [2:0] t;
    t = TYPE_NONE;
    if ((w & HDR_MASK) == HDR_MASK) begin
      case (w[23:8])
        16'h0000: t = TYPE_1;
        16'h000A: t = TYPE_2;
        16'h00AA: t = TYPE_3;
        16'h0AAA: t = TYPE_4;
        16'hAAAA: t = TYPE_5;
        default:  t = TYPE_NONE;
      endcase
    end
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_dpram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_dpram : simple dual-port RAM, one write port, registered read     |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module pkt_dpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data <= mem_q[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/pkt_cache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_cache_ctrl : ping-pong packet cache between USB3 RX and the DAC   |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module pkt_cache_ctrl
  import pkt_cache_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PKT_LEN = 256,
  parameter int CH_NUM  = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  input  logic              rd_start,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [2:0]        rd_pkt_type,
  output logic [CH_NUM-1:0] dac_wren,
  output logic              empty,
  output logic              full,
  output logic              hdr_err,
  output logic              ovf
);

  localparam int AW = $clog2(PKT_LEN);
  localparam logic [AW-1:0] LAST_ADDR = AW'(PKT_LEN - 1);

  wr_state_t         wr_state_q, wr_state_d;
  rd_state_t         rd_state_q, rd_state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [1:0]        full_q, full_d;
  logic [1:0][2:0]   type_q, type_d;
  logic [2:0]        rd_type_q, rd_type_d;
  logic              pipe_vld_q, pipe_vld_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [CH_NUM-1:0] dac_wren_q, dac_wren_d;
  logic              hdr_err_q, hdr_err_d;
  logic              ovf_q, ovf_d;
  logic [2:0]        hdr_t;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign hdr_t  = hdr_type(wr_data[31:0]);
  assign mem_we = wr_valid && (wr_state_q == W_PAY);

  pkt_dpram #(.DATA_W(DATA_W), .ADDR_W(AW + 1)) u_mem (
    .clock   (clock),
    .wr_en   (mem_we),
    .wr_addr ({wr_bank_q, wr_addr_q}),
    .wr_data (wr_data),
    .rd_addr ({rd_bank_q, rd_addr_q}),
    .rd_data (mem_rdata)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    full_d     = full_q;
    type_d     = type_q;
    rd_type_d  = rd_type_q;
    hdr_err_d  = 1'b0;
    ovf_d      = 1'b0;

    // Banks are filled and drained in the same 0,1,0... order, so the
    // read pointer always names the oldest full bank.
    case (rd_state_q)
      R_IDLE: begin
        if (rd_start && (full_q != 2'b00)) begin
          rd_type_d  = type_q[rd_bank_q];
          rd_addr_d  = '0;
          rd_state_d = R_RUN;
        end
      end
      R_RUN: begin
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_addr_q == LAST_ADDR) rd_state_d = R_LAST;
      end
      R_LAST: begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_state_d        = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase

    // A bank still being played out keeps its full flag, so it never looks free.
    case (wr_state_q)
      W_HDR: begin
        if (wr_valid) begin
          wr_addr_d = '0;
          if (hdr_t == TYPE_NONE) begin
            hdr_err_d = 1'b1;
          end else if (!full_q[wr_bank_q]) begin
            type_d[wr_bank_q] = hdr_t;
            wr_state_d        = W_PAY;
          end else begin
            ovf_d      = 1'b1;
            wr_state_d = W_DROP;
          end
        end
      end
      W_PAY: begin
        if (wr_valid) begin
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_state_d        = W_HDR;
          end
        end
      end
      W_DROP: begin
        if (wr_valid) begin
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == LAST_ADDR) wr_state_d = W_HDR;
        end
      end
      default: wr_state_d = W_HDR;
    endcase

    pipe_vld_d = (rd_state_q == R_RUN);
    rd_valid_d = pipe_vld_q;
    rd_data_d  = pipe_vld_q ? mem_rdata : '0;
    dac_wren_d = {CH_NUM{pipe_vld_q}};
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_HDR;
      rd_state_q <= R_IDLE;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      full_q     <= 2'b00;
      type_q     <= '0;
      rd_type_q  <= 3'd0;
      pipe_vld_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      dac_wren_q <= '0;
      hdr_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      full_q     <= full_d;
      type_q     <= type_d;
      rd_type_q  <= rd_type_d;
      pipe_vld_q <= pipe_vld_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      dac_wren_q <= dac_wren_d;
      hdr_err_q  <= hdr_err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_pkt_type = rd_type_q;
  assign dac_wren    = dac_wren_q;
  assign hdr_err     = hdr_err_q;
  assign ovf         = ovf_q;
  assign empty       = ~(full_q[0] | full_q[1]);
  assign full        = full_q[0] & full_q[1];

endmodule
`default_nettype wire

// File: doc/pkt_cache_ctrl.md
PKT_CACHE_CTRL -- requirements
Module: pkt_cache_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width; at least 32.
REQ-002 SHALL have parameter PKT_LEN, default 256: payload words per packet; a power of 2, at least 4.
REQ-003 SHALL have parameter CH_NUM, default 16: width of the DAC write-enable vector.
REQ-004 SHALL have port clock, input, 1: the single clock; every flop is on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port wr_data, input, DATA_W: USB3 receive word.
REQ-007 SHALL have port wr_valid, input, 1: wr_data is valid this cycle.
REQ-008 SHALL have port rd_start, input, 1: one-cycle request to play out one packet.
REQ-009 SHALL have port rd_data, output, DATA_W: payload word to the DAC.
REQ-010 SHALL have port rd_valid, output, 1: rd_data is valid this cycle.
REQ-011 SHALL have port rd_pkt_type, output, 3: type code of the packet being played out.
REQ-012 SHALL have port dac_wren, output, CH_NUM: per-channel DAC write enable.
REQ-013 SHALL have port empty, output, 1: no full bank is waiting.
REQ-014 SHALL have port full, output, 1: both banks are full.
REQ-015 SHALL have port hdr_err, output, 1: one-cycle pulse on a bad header.
REQ-016 SHALL have port ovf, output, 1: one-cycle pulse when a packet is dropped.

Function
REQ-017 SHALL buffer packets in two banks of PKT_LEN words (ping-pong); each bank carries a full flag and a 3-bit type.
REQ-018 SHALL run the write FSM with states W_HDR, W_PAY and W_DROP; it SHALL advance only on cycles where wr_valid=1, and a gap in wr_valid SHALL stall it without loss.
REQ-019 SHALL treat a word in W_HDR as a header when (wr_data[31:0] AND FF0000FF) = FF0000FF.
- Field wr_data[23:8] SHALL map 0000->1, 000A->2, 00AA->3, 0AAA->4, AAAA->5.
REQ-020 SHALL, for a non-header word or unknown code in W_HDR, pulse hdr_err for one cycle, drop the word and stay in W_HDR.
REQ-021 SHALL, on a valid header with a free bank, latch the type into that bank and go to W_PAY.
- Write bank selection SHALL alternate 0, 1, 0, ...
REQ-022 SHALL, on a valid header with no free bank, pulse ovf and go to W_DROP.
- W_DROP SHALL discard PKT_LEN valid words, then return to W_HDR.
REQ-023 SHALL, in W_PAY, write valid words to addresses 0..PKT_LEN-1 of the selected bank.
- On the last word it SHALL set the bank's full flag on the following edge and return to W_HDR.
- The address SHALL wrap to 0 without carry into the bank select.
REQ-024 SHALL run the read FSM with states R_IDLE, R_RUN and R_LAST.
- rd_start in R_IDLE with empty=0 SHALL enter R_RUN on the oldest full bank.
- rd_start while empty=1, or outside R_IDLE, SHALL be ignored.
REQ-025 SHALL, in R_RUN, issue one read address per cycle for addresses 0..PKT_LEN-1.
- Memory read latency SHALL be 1 cycle: rd_valid=1 for exactly PKT_LEN consecutive cycles, starting 2 cycles after the rd_start edge.
REQ-026 SHALL hold rd_pkt_type stable from the first rd_valid through the last rd_valid.
REQ-027 SHALL drive dac_wren to all ones when rd_valid=1, and to all zeros otherwise.
REQ-028 SHALL clear the bank's full flag in R_LAST, one cycle after the last address, then return to R_IDLE.
REQ-029 SHALL honour a fill and a release of the same bank in the same cycle, with no flag lost.
- A write into a bank currently being read SHALL never occur: that bank stays non-free until it is released.
REQ-030 SHALL make empty and full combinational functions of the two full flags.

Reset
REQ-031 SHALL, while rst=1, put the FSMs in W_HDR and R_IDLE and clear both flags, both types and all pointers.
REQ-032 SHALL hold outputs at reset as follows: rd_data=0, rd_valid=0, rd_pkt_type=0, dac_wren=0, empty=1, full=0, hdr_err=0, ovf=0.
REQ-033 SHALL, on reset mid-packet, discard the partial packet; the first valid word after reset is parsed as a header.

Structure
REQ-034 SHALL keep the header mask, the type codes 1..5 and the FSM state encodings in a shared package, pkt_cache_pkg.
REQ-035 SHALL put the storage in one sub-module, pkt_dpram: simple dual-port, depth 2*PKT_LEN, registered read, bank select as the address MSB.

Verification
REQ-036 SHALL cover: header FF00AAFF followed by 256 words 0..255, then rd_start -> rd_valid for 256 cycles, rd_data 0..255, rd_pkt_type=3, dac_wren=FFFF.
REQ-037 SHALL cover: header 12345678 -> hdr_err for 1 cycle; a following FF0000FF packet is accepted with type 1.
REQ-038 SHALL cover: three packets written with no reads -> full=1 after the second, ovf after the third header, and the third packet's data never appears on rd_data.
REQ-039 SHALL cover: rd_start while empty=1 -> rd_valid stays 0; rd_start during R_RUN -> no extra rd_valid cycles.
REQ-040 SHALL cover: wr_valid toggling every cycle during the payload -> readback data matches exactly.
REQ-041 SHALL cover: rst asserted at payload word 100 -> empty=1, and a clean packet afterwards reads back correctly.
